// File: rtl/ws2812_pkg.sv
// Shared types, GRB field layout and 50 MHz default timing for the WS2812 chain fader.
// The optional gamma-corrected fade is selected with the WS2812_GAMMA_EN macro (see ws2812_chain_fader).
package ws2812_pkg;

  localparam int CH_W   = 8;
  localparam int WORD_W = 3 * CH_W;

  localparam int G_MSB = 23;
  localparam int G_LSB = 16;
  localparam int R_MSB = 15;
  localparam int R_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  localparam int DEF_NUM_LEDS  = 8;
  localparam int DEF_T0H_CYC   = 20;
  localparam int DEF_T1H_CYC   = 40;
  localparam int DEF_BIT_CYC   = 62;
  localparam int DEF_RESET_CYC = 3000;
  localparam int DEF_FADE_STEP = 4;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_FADE   = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } fsm_state_e;

  // c * g >> 8 with g in 1..256; the product never exceeds 16 bits.
  function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c,
                                               input logic [CH_W:0]   g);
    logic [2*CH_W-1:0] prod;
    prod = (2*CH_W)'(c) * (2*CH_W)'(g);
    return CH_W'(prod >> CH_W);
  endfunction

endpackage

// File: rtl/ws2812_bit_serializer.sv
// Shifts a 24-bit GRB word out MSB first as WS2812 timed bits, one word per load handshake.
// word_done marks the last cycle of the final bit so the next word can follow without a gap.
module ws2812_bit_serializer
  import ws2812_pkg::*;
#(
  parameter int T0H_CYC = DEF_T0H_CYC,
  parameter int T1H_CYC = DEF_T1H_CYC,
  parameter int BIT_CYC = DEF_BIT_CYC
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WORD_W-1:0] load_word,
  output logic              data_out,
  output logic              word_done
);

  localparam int CYC_W = $clog2(BIT_CYC);
  localparam int BIT_W = 5;
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(BIT_CYC - 1);
  localparam logic [CYC_W-1:0] T0H      = CYC_W'(T0H_CYC);
  localparam logic [CYC_W-1:0] T1H      = CYC_W'(T1H_CYC);

  logic [WORD_W-1:0] word_q, word_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic              active_q, active_d;
  logic              out_q, out_d;

  // Handshake: a word transfers on a cycle where load_valid && load_ready; the
  // source holds load_word stable while load_valid is high and ready is low.
  assign word_done  = active_q && (bit_q == '0) && (cyc_q == LAST_CYC);
  assign load_ready = !active_q || word_done;
  assign data_out   = out_q;

  always_comb begin
    word_d   = word_q;
    bit_d    = bit_q;
    cyc_d    = cyc_q;
    active_d = active_q;
    if (load_valid && load_ready) begin
      word_d   = load_word;
      bit_d    = BIT_W'(WORD_W - 1);
      cyc_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cyc_q == LAST_CYC) begin
        cyc_d = '0;
        if (bit_q == '0) begin
          active_d = 1'b0;
        end else begin
          bit_d  = bit_q - BIT_W'(1);
          word_d = {word_q[WORD_W-2:0], 1'b0};
        end
      end else begin
        cyc_d = cyc_q + CYC_W'(1);
      end
    end
    // Output is registered from next-state values so it lines up with the bit counters.
    out_d = active_d && (cyc_d < (word_d[WORD_W-1] ? T1H : T0H));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word_q   <= '0;
      bit_q    <= '0;
      cyc_q    <= '0;
      active_q <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      word_q   <= word_d;
      bit_q    <= bit_d;
      cyc_q    <= cyc_d;
      active_q <= active_d;
      out_q    <= out_d;
    end
  end

endmodule

// File: rtl/ws2812_chain_fader.sv
// Frame FSM, per-pixel colour scaler and fade/chase counters for a WS2812 chain.
// Define WS2812_GAMMA_EN to use the squared (perceptual) fade multiplier instead of the linear one.
module ws2812_chain_fader
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS  = DEF_NUM_LEDS,
  parameter int T0H_CYC   = DEF_T0H_CYC,
  parameter int T1H_CYC   = DEF_T1H_CYC,
  parameter int BIT_CYC   = DEF_BIT_CYC,
  parameter int RESET_CYC = DEF_RESET_CYC,
  parameter int FADE_STEP = DEF_FADE_STEP
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [23:0] base_color,
  output logic        ws2812_out,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  brightness
);

  localparam int IDX_W = $clog2(NUM_LEDS + 1);
  localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int LAT_W = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;
  localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(NUM_LEDS);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_LEDS - 1);
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(RESET_CYC - 1);
  localparam logic [CH_W:0]    STEP9    = (CH_W+1)'(FADE_STEP);

  fsm_state_e        state_q, state_d;
  mode_e             frame_mode_q, frame_mode_d;
  logic [WORD_W-1:0] frame_color_q, frame_color_d;
  logic [IDX_W-1:0]  pix_q, pix_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [CH_W-1:0]   bright_q, bright_d;
  logic              dir_down_q, dir_down_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              ser_valid, ser_ready, ser_done, ser_out;
  logic [WORD_W-1:0] ser_word;
  mode_e             cur_mode;
  logic [WORD_W-1:0] cur_color;
  logic [IDX_W-1:0]  cur_idx;
  logic [CH_W:0]     gain;
`ifdef WS2812_GAMMA_EN
  logic [2*CH_W-1:0] bright_sq;
`endif

  assign ws2812_out = ser_out;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign brightness = bright_q;

  // Pixel 0 is built in LOAD straight from the inputs, the rest from the frame registers.
  always_comb begin
    cur_mode  = frame_mode_q;
    cur_color = frame_color_q;
    cur_idx   = pix_q;
    if (state_q == ST_LOAD) begin
      cur_mode  = mode_e'(mode);
      cur_color = base_color;
      cur_idx   = '0;
    end
`ifdef WS2812_GAMMA_EN
    bright_sq = (2*CH_W)'(bright_q) * (2*CH_W)'(bright_q);
    gain      = (CH_W+1)'(bright_sq >> CH_W) + (CH_W+1)'(1);
`else
    gain      = (CH_W+1)'(bright_q) + (CH_W+1)'(1);
`endif
    case (cur_mode)
      MODE_FADE:  ser_word = {scale_ch(cur_color[G_MSB:G_LSB], gain),
                              scale_ch(cur_color[R_MSB:R_LSB], gain),
                              scale_ch(cur_color[B_MSB:B_LSB], gain)};
      MODE_CHASE: ser_word = (cur_idx == IDX_W'(pos_q)) ? cur_color : '0;
      default:    ser_word = cur_color;
    endcase
    ser_valid = (state_q == ST_LOAD) || ((state_q == ST_SEND) && (pix_q != END_IDX));
  end

  always_comb begin
    state_d       = state_q;
    frame_mode_d  = frame_mode_q;
    frame_color_d = frame_color_q;
    pix_d         = pix_q;
    pos_d         = pos_q;
    bright_d      = bright_q;
    dir_down_d    = dir_down_q;
    lat_d         = lat_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        frame_mode_d  = mode_e'(mode);
        frame_color_d = base_color;
        pix_d         = IDX_W'(1);
        state_d       = ST_SEND;
      end
      ST_SEND: begin
        if (ser_valid && ser_ready) pix_d = pix_q + IDX_W'(1);
        if (ser_done && (pix_q == END_IDX)) begin
          state_d = ST_LATCH;
          lat_d   = '0;
        end
      end
      default: begin
        if (lat_q == LAST_LAT) begin
          state_d = enable ? ST_LOAD : ST_IDLE;
          if (frame_mode_q == MODE_FADE) begin
            if (!dir_down_q) begin
              if (((CH_W+1)'(bright_q) + STEP9) >= (CH_W+1)'(255)) begin
                bright_d   = 8'd255;
                dir_down_d = 1'b1;
              end else begin
                bright_d = bright_q + STEP9[CH_W-1:0];
              end
            end else begin
              if ((CH_W+1)'(bright_q) <= STEP9) begin
                bright_d   = '0;
                dir_down_d = 1'b0;
              end else begin
                bright_d = bright_q - STEP9[CH_W-1:0];
              end
            end
          end
          if (frame_mode_q == MODE_CHASE) begin
            pos_d = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_LATCH) && (lat_d == LAST_LAT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      frame_mode_q  <= MODE_STATIC;
      frame_color_q <= '0;
      pix_q         <= '0;
      pos_q         <= '0;
      bright_q      <= '0;
      dir_down_q    <= 1'b0;
      lat_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_mode_q  <= frame_mode_d;
      frame_color_q <= frame_color_d;
      pix_q         <= pix_d;
      pos_q         <= pos_d;
      bright_q      <= bright_d;
      dir_down_q    <= dir_down_d;
      lat_q         <= lat_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  ws2812_bit_serializer #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC)
  ) u_ser (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (ser_valid),
    .load_ready (ser_ready),
    .load_word  (ser_word),
    .data_out   (ser_out),
    .word_done  (ser_done)
  );

endmodule

// File: tb/tb_ws2812_chain_fader.sv
// Directed bench: one default-timing chain (2 LEDs) and two short-timing chains (4 and 8 LEDs)
// whose serial output is decoded back into GRB words and compared with hand-computed values.
`timescale 1ns/1ps
module tb_ws2812_chain_fader;

  localparam int A_N = 2;
  localparam int B_N = 4;
  localparam int C_N = 8;

`ifdef WS2812_GAMMA_EN
  localparam logic [23:0] FW2 = 24'h000000, FW3 = 24'h000000, FW4 = 24'h000000;
  localparam logic [23:0] FW64 = 24'h7c7c7c, FW65 = 24'h7f7f7f, FW66 = 24'h7b7b7b;
`else
  localparam logic [23:0] FW2 = 24'h020202, FW3 = 24'h040404, FW4 = 24'h060606;
  localparam logic [23:0] FW64 = 24'h7e7e7e, FW65 = 24'h808080, FW66 = 24'h7e7e7e;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        a_rst_n, a_en, a_out, a_busy, a_done;
  logic        b_rst_n, b_en, b_out, b_busy, b_done;
  logic        c_rst_n, c_en, c_out, c_busy, c_done;
  logic [1:0]  a_mode, b_mode, c_mode;
  logic [23:0] a_color, b_color, c_color;
  logic [7:0]  a_bright, b_bright, c_bright;

  ws2812_chain_fader #(.NUM_LEDS(A_N)) u_dut_a (
    .clk(clk), .reset_n(a_rst_n), .enable(a_en), .mode(a_mode), .base_color(a_color),
    .ws2812_out(a_out), .busy(a_busy), .frame_done(a_done), .brightness(a_bright));

  ws2812_chain_fader #(.NUM_LEDS(B_N), .T0H_CYC(2), .T1H_CYC(4), .BIT_CYC(6),
                       .RESET_CYC(10), .FADE_STEP(4)) u_dut_b (
    .clk(clk), .reset_n(b_rst_n), .enable(b_en), .mode(b_mode), .base_color(b_color),
    .ws2812_out(b_out), .busy(b_busy), .frame_done(b_done), .brightness(b_bright));

  ws2812_chain_fader #(.NUM_LEDS(C_N), .T0H_CYC(2), .T1H_CYC(4), .BIT_CYC(6),
                       .RESET_CYC(10), .FADE_STEP(4)) u_dut_c (
    .clk(clk), .reset_n(c_rst_n), .enable(c_en), .mode(c_mode), .base_color(c_color),
    .ws2812_out(c_out), .busy(c_busy), .frame_done(c_done), .brightness(c_bright));

  int sel = 0;
  logic       mon_out, mon_busy, mon_done;
  logic [7:0] mon_bright;
  assign mon_out    = (sel == 0) ? a_out    : (sel == 1) ? b_out    : c_out;
  assign mon_busy   = (sel == 0) ? a_busy   : (sel == 1) ? b_busy   : c_busy;
  assign mon_done   = (sel == 0) ? a_done   : (sel == 1) ? b_done   : c_done;
  assign mon_bright = (sel == 0) ? a_bright : (sel == 1) ? b_bright : c_bright;

  int checks = 0;
  int failures = 0;

  logic [23:0] cap_word [0:7];
  int          cap_bad, cap_lat, cap_lat_hi, cap_glitch, cap_len;
  logic        cap_timeout, cap_load_out;
  logic [7:0]  cap_bright;

  // Decodes one frame on the selected DUT starting from its LOAD cycle and
  // returns at the negedge of the frame_done cycle.
  task automatic capture_frame(input int n_px, input int bitc, input int t0, input int t1);
    int guard, h;
    bit shape_ok;
    logic [23:0] w;
    cap_bad = 0; cap_lat = 0; cap_lat_hi = 0; cap_glitch = 0; cap_len = 0;
    cap_timeout = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (mon_busy !== 1'b1 && guard < 20000);
    if (mon_busy !== 1'b1) begin
      cap_timeout = 1'b1;
      return;
    end
    cap_len = 1;
    cap_load_out = mon_out;
    cap_bright = mon_bright;
    if (mon_done !== 1'b0) cap_glitch++;
    for (int p = 0; p < n_px; p++) begin
      w = '0;
      for (int b = 0; b < 24; b++) begin
        h = 0;
        shape_ok = 1'b1;
        for (int c = 0; c < bitc; c++) begin
          @(negedge clk);
          cap_len++;
          if (mon_out === 1'b1) begin
            if (h != c) shape_ok = 1'b0;
            h++;
          end else if (mon_out !== 1'b0) begin
            shape_ok = 1'b0;
          end
          if (mon_done !== 1'b0 || mon_busy !== 1'b1) cap_glitch++;
        end
        w = {w[22:0], (h == t1)};
        if (!shape_ok || (h != t0 && h != t1)) cap_bad++;
      end
      cap_word[p] = w;
    end
    do begin
      @(negedge clk);
      cap_len++;
      cap_lat++;
      if (mon_out !== 1'b0) cap_lat_hi++;
      if (mon_busy !== 1'b1) cap_glitch++;
    end while (mon_done !== 1'b1 && cap_lat < 20000);
    if (mon_done !== 1'b1) cap_timeout = 1'b1;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
    a_en = 1'b0; b_en = 1'b0; c_en = 1'b0;
    a_mode = 2'd0; b_mode = 2'd0; c_mode = 2'd0;
    a_color = '0; b_color = '0; c_color = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (mon_out !== 1'b0) begin failures++; $display("FAIL reset_out dut=%0d got=%b exp=0", s, mon_out); end
      checks++;
      if (mon_busy !== 1'b0) begin failures++; $display("FAIL reset_busy dut=%0d got=%b exp=0", s, mon_busy); end
      checks++;
      if (mon_done !== 1'b0) begin failures++; $display("FAIL reset_done dut=%0d got=%b exp=0", s, mon_done); end
      checks++;
      if (mon_bright !== 8'd0) begin failures++; $display("FAIL reset_bright dut=%0d got=%0d exp=0", s, mon_bright); end
    end
    @(negedge clk);
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_static();
    sel = 0;
    a_mode = 2'd0;
    a_color = 24'hFF0000;
    a_en = 1'b1;
    @(posedge clk);
    #1 a_en = 1'b0;
    capture_frame(A_N, 62, 20, 40);
    checks++;
    if (cap_timeout) begin failures++; $display("FAIL static_timeout got=1 exp=0"); end
    checks++;
    if (cap_load_out !== 1'b0) begin failures++; $display("FAIL static_load_out got=%b exp=0", cap_load_out); end
    for (int p = 0; p < A_N; p++) begin
      checks++;
      if (cap_word[p] !== 24'hFF0000) begin failures++; $display("FAIL static_px%0d got=%h exp=ff0000", p, cap_word[p]); end
    end
    checks++;
    if (cap_bad != 0) begin failures++; $display("FAIL static_bit_shape got=%0d bad bits exp=0", cap_bad); end
    checks++;
    if (cap_glitch != 0) begin failures++; $display("FAIL static_glitch got=%0d exp=0", cap_glitch); end
    checks++;
    if (cap_lat != 3000) begin failures++; $display("FAIL static_latch_len got=%0d exp=3000", cap_lat); end
    checks++;
    if (cap_lat_hi != 0) begin failures++; $display("FAIL static_latch_high got=%0d exp=0", cap_lat_hi); end
    checks++;
    if (cap_len != 5977) begin failures++; $display("FAIL static_busy_len got=%0d exp=5977", cap_len); end
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0) begin failures++; $display("FAIL static_busy_drop got=%b exp=0", a_busy); end
  endtask

  task automatic test_midframe_change();
    sel = 0;
    a_mode = 2'd0;
    a_color = 24'h123456;
    a_en = 1'b1;
    fork
      capture_frame(A_N, 62, 20, 40);
      begin
        repeat (300) @(negedge clk);
        a_mode = 2'd2;
        a_color = 24'hABCDEF;
      end
    join
    for (int p = 0; p < A_N; p++) begin
      checks++;
      if (cap_timeout || cap_word[p] !== 24'h123456) begin
        failures++; $display("FAIL midchg_old_px%0d got=%h exp=123456 timeout=%b", p, cap_word[p], cap_timeout);
      end
    end
    fork
      capture_frame(A_N, 62, 20, 40);
      begin
        repeat (300) @(negedge clk);
        a_en = 1'b0;
      end
    join
    checks++;
    if (cap_timeout || cap_word[0] !== 24'hABCDEF) begin
      failures++; $display("FAIL midchg_new_px0 got=%h exp=abcdef timeout=%b", cap_word[0], cap_timeout);
    end
    checks++;
    if (cap_word[1] !== 24'h000000) begin failures++; $display("FAIL midchg_new_px1 got=%h exp=000000", cap_word[1]); end
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0) begin failures++; $display("FAIL midchg_idle got=%b exp=0", a_busy); end
  endtask

  task automatic test_fade();
    logic [23:0] exp_w;
    logic [7:0]  exp_b;
    bit chk_w, chk_b;
    sel = 1;
    b_mode = 2'd1;
    b_color = 24'h808080;
    b_en = 1'b1;
    for (int f = 1; f <= 66; f++) begin
      capture_frame(B_N, 6, 2, 4);
      checks++;
      if (cap_timeout || cap_bad != 0 || cap_glitch != 0 || cap_lat != 10) begin
        failures++;
        $display("FAIL fade_frame%0d timeout=%b bad=%0d glitch=%0d latch=%0d exp latch=10", f, cap_timeout, cap_bad, cap_glitch, cap_lat);
        if (cap_timeout) break;
      end
      chk_w = 1'b1; chk_b = 1'b1; exp_w = '0; exp_b = '0;
      case (f)
        1:  begin exp_w = 24'h000000; exp_b = 8'd0;   end
        2:  begin exp_w = FW2;        exp_b = 8'd4;   end
        3:  begin exp_w = FW3;        exp_b = 8'd8;   end
        4:  begin exp_w = FW4;        exp_b = 8'd12;  end
        64: begin exp_w = FW64;       exp_b = 8'd252; end
        65: begin exp_w = FW65;       exp_b = 8'd255; end
        66: begin exp_w = FW66;       exp_b = 8'd251; end
        default: begin chk_w = 1'b0; chk_b = 1'b0; end
      endcase
      if (chk_b) begin
        checks++;
        if (cap_bright !== exp_b) begin failures++; $display("FAIL fade_bright_frame%0d got=%0d exp=%0d", f, cap_bright, exp_b); end
      end
      if (chk_w) begin
        for (int p = 0; p < B_N; p++) begin
          checks++;
          if (cap_word[p] !== exp_w) begin failures++; $display("FAIL fade_word_frame%0d_px%0d got=%h exp=%h", f, p, cap_word[p], exp_w); end
        end
      end
    end
  endtask

  task automatic test_chase();
    logic [23:0] exp_w;
    sel = 1;
    b_mode = 2'd2;
    b_color = 24'h00FF00;
    for (int f = 0; f < 5; f++) begin
      capture_frame(B_N, 6, 2, 4);
      checks++;
      if (cap_timeout || cap_bad != 0) begin
        failures++; $display("FAIL chase_frame%0d timeout=%b bad=%0d exp 0/0", f, cap_timeout, cap_bad);
        if (cap_timeout) break;
      end
      checks++;
      if (cap_bright !== 8'd247) begin failures++; $display("FAIL chase_bright_hold frame%0d got=%0d exp=247", f, cap_bright); end
      for (int p = 0; p < B_N; p++) begin
        exp_w = (p == f % 4) ? 24'h00FF00 : 24'h000000;
        checks++;
        if (cap_word[p] !== exp_w) begin failures++; $display("FAIL chase_frame%0d_px%0d got=%h exp=%h", f, p, cap_word[p], exp_w); end
      end
    end
  endtask

  task automatic test_reset_mid_send();
    sel = 1;
    repeat (100) @(negedge clk);
    b_rst_n = 1'b0;
    b_en = 1'b0;
    @(negedge clk);
    checks++;
    if (b_out !== 1'b0) begin failures++; $display("FAIL rstmid_out got=%b exp=0", b_out); end
    checks++;
    if (b_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", b_busy); end
    checks++;
    if (b_bright !== 8'd0) begin failures++; $display("FAIL rstmid_bright got=%0d exp=0", b_bright); end
    b_rst_n = 1'b1;
    b_en = 1'b1;
    @(posedge clk);
    #1 b_en = 1'b0;
    capture_frame(B_N, 6, 2, 4);
    checks++;
    if (cap_timeout || cap_word[0] !== 24'h00FF00) begin
      failures++; $display("FAIL rstmid_px0 got=%h exp=00ff00 timeout=%b", cap_word[0], cap_timeout);
    end
    for (int p = 1; p < B_N; p++) begin
      checks++;
      if (cap_word[p] !== 24'h000000) begin failures++; $display("FAIL rstmid_px%0d got=%h exp=000000", p, cap_word[p]); end
    end
    @(negedge clk);
    checks++;
    if (b_busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle got=%b exp=0", b_busy); end
  endtask

  task automatic test_enable_drop();
    int n_busy, n_hi, n_done;
    sel = 2;
    c_mode = 2'd0;
    c_color = 24'hA5C3F0;
    c_en = 1'b1;
    fork
      capture_frame(C_N, 6, 2, 4);
      begin
        repeat (450) @(negedge clk);
        c_en = 1'b0;
      end
    join
    checks++;
    if (cap_timeout || cap_bad != 0 || cap_glitch != 0 || cap_lat != 10) begin
      failures++; $display("FAIL endrop_frame timeout=%b bad=%0d glitch=%0d latch=%0d exp latch=10", cap_timeout, cap_bad, cap_glitch, cap_lat);
    end
    for (int p = 0; p < C_N; p++) begin
      checks++;
      if (cap_word[p] !== 24'hA5C3F0) begin failures++; $display("FAIL endrop_px%0d got=%h exp=a5c3f0", p, cap_word[p]); end
    end
    n_busy = 0; n_hi = 0; n_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (c_busy !== 1'b0) n_busy++;
      if (c_out !== 1'b0) n_hi++;
      if (c_done !== 1'b0) n_done++;
    end
    checks++;
    if (n_busy != 0) begin failures++; $display("FAIL endrop_idle_busy got=%0d exp=0", n_busy); end
    checks++;
    if (n_hi != 0) begin failures++; $display("FAIL endrop_idle_out got=%0d exp=0", n_hi); end
    checks++;
    if (n_done != 0) begin failures++; $display("FAIL endrop_extra_done got=%0d exp=0", n_done); end
  endtask

  initial begin
    test_reset();
    test_static();
    test_midframe_change();
    test_fade();
    test_chase();
    test_reset_mid_send();
    test_enable_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ws2812_chain_fader.md
Name: ws2812_chain_fader

Overview:
- Parametrised successor to the single-pattern WS2812 fade controller.
- Drives a chain of NUM_LEDS WS2812 pixels from one 24-bit GRB base colour, with selectable static, breathing-fade and chase modes.
- Sits directly under the DE10-Lite board wrapper: clk from the 50 MHz pin, reset_n from KEY[0], ws2812_out to the Arduino IO pin.

Parameters:
- NUM_LEDS, 8, pixels in the chain (1..1024).
- T0H_CYC, 20, high time of a '0' bit in clk cycles (0.4 us at 50 MHz).
- T1H_CYC, 40, high time of a '1' bit in clk cycles (0.8 us).
- BIT_CYC, 62, total bit period in clk cycles (1.24 us).
- RESET_CYC, 3000, low latch time after a frame (60 us).
- FADE_STEP, 4, brightness increment per frame in fade mode (1..255).

Ports:
- clk  input  1  system clock, 50 MHz.
- reset_n  input  1  synchronous reset, active-low.
- enable  input  1  run frames continuously while high.
- mode  input  2  0 = static, 1 = fade, 2 = chase, 3 = reserved (treated as static).
- base_color  input  24  GRB colour, G[23:16], R[15:8], B[7:0].
- ws2812_out  output  1  serial data to the chain.
- busy  output  1  high from frame start through the end of the latch.
- frame_done  output  1  one-cycle pulse in the last latch cycle.
- brightness  output  8  current fade brightness.

Behaviour:
- Reset: one clock, synchronous, active-low (reset_n). While reset_n is low at a clk edge:
  - ws2812_out=0, busy=0, frame_done=0, brightness=0;
  - fade direction = up, chase position = 0, FSM = IDLE, all counters 0.
  - Reset asserted mid-bit truncates the frame immediately. The line stays low, so the chain latches partial data; this is accepted.
- FSM states: IDLE -> LOAD -> SEND -> LATCH -> (LOAD if enable, else IDLE).
- IDLE: ws2812_out=0, busy=0. enable=1 moves to LOAD on the next cycle.
- LOAD (1 cycle):
  - Samples mode and base_color into frame registers; changes mid-frame have no effect.
  - Computes the first pixel word. busy goes high.
- SEND:
  - For pixel index 0..NUM_LEDS-1, shifts 24 bits MSB first (G7 first).
  - Each bit lasts BIT_CYC cycles. ws2812_out=1 for cycles 0..THx_CYC-1 of the bit, else 0.
  - The next pixel word is computed during the current pixel; there are no gaps between bits.
- LATCH:
  - ws2812_out=0 for RESET_CYC cycles. frame_done pulses in the final cycle.
  - Brightness and chase position update in that same cycle.
- Frame length is exactly 1 + NUM_LEDS*24*BIT_CYC + RESET_CYC cycles. Default: 1 + 11904 + 3000 = 14905.
- enable deasserted mid-frame: the current frame, including its latch, completes, then the FSM goes to IDLE.
- Pixel word per mode:
  - static: every pixel = base_color.
  - fade: each channel c -> (c * (brightness+1)) >> 8. The 8x9-bit product is 17 bits wide; take bits [15:8]. brightness=255 gives exactly c; brightness=0 gives c>>8 = 0.
  - chase: pixel i = base_color if i == pos, else 0.
- Fade update (fade mode only; brightness holds in other modes):
  - Going up: if brightness + FADE_STEP >= 255, set 255 and reverse direction; else add FADE_STEP.
  - Going down: if brightness <= FADE_STEP, set 0 and reverse direction; else subtract FADE_STEP.
- Chase update: pos increments once per frame; NUM_LEDS-1 wraps to 0. pos holds in other modes.

Optional Feature:
- Macro: WS2812_GAMMA_EN.
- Defined: the fade multiplier uses g = ((brightness*brightness) >> 8) + 1 instead of brightness+1, giving a perceptually linear fade. Example: brightness 128 -> g = 65.
- Undefined: the linear multiplier above is used. The brightness port always shows the raw, un-gamma'd value.

Decomposition:
- Package ws2812_pkg holds:
  - mode_e enum (MODE_STATIC, MODE_FADE, MODE_CHASE, MODE_RSVD);
  - fsm_state_e;
  - default timing constants for 50 MHz;
  - the GRB field slice widths.
- Sub-module ws2812_bit_serializer:
  - Loads a 24-bit word on load_valid/load_ready and emits its timed bits.
  - Asserts word_done in the last cycle of bit 0.
  - The top-level FSM, scaler and fade/chase counters stay in ws2812_chain_fader.

Test Plan:
- static, base_color=24'hFF0000, NUM_LEDS=2: per pixel, 8 high pulses of 40 cycles then 16 of 20 cycles, every bit period 62; busy drops 1+2976+3000 cycles after start.
- fade, FADE_STEP=4, base_color=24'h808080: brightness after frames 1..3 = 4, 8, 12; brightness 255 reached at frame 64 then steps down to 251; frame with brightness 255 sends 0x80 per channel.
- chase, NUM_LEDS=4, base_color=24'h00FF00: lit pixel index per frame = 0, 1, 2, 3, 0; unlit pixels send 24 zero bits.
- mode and base_color changed mid-SEND: current frame still uses the old values; the new values appear on the next frame.
- enable dropped during pixel 3 of 8: frame completes, frame_done pulses once, FSM returns to IDLE, ws2812_out stays 0.
- reset_n low during SEND: next-cycle ws2812_out=0, busy=0, brightness=0; re-enable starts a fresh frame with pos=0.
